mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max cycles waited for mem_mfc before aborting (1..255).
REQ-002 SHALL have parameter STARVE_LIM, default 2, consecutive data grants allowed while fetch is pending (1..3).
REQ-003 SHALL have port clk, input, 1: clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have ports if_req, if_rw, if_addr: input, 1/1/16: fetch requester request, 1=read, address.
REQ-006 SHALL have ports ls_req, ls_rw, ls_addr, ls_wdata: input, 1/1/16/16: load/store requester request, 1=read, address, write data.
REQ-007 SHALL have ports if_gnt, if_done, ls_gnt, ls_done: output, 1 each: per-requester grant and one-cycle completion pulse.
REQ-008 SHALL have port rdata, output, 16: read data captured from memory, shared by both requesters.
REQ-009 SHALL have port err, output, 1: one-cycle pulse, accompanies done, on timeout abort.
REQ-010 SHALL have ports mem_en, mem_rw, mem_addr, mem_wdata: output, 1/1/16/16: memory enable, direction, address, write data.
REQ-011 SHALL have ports mem_mfc, mem_rdata: input, 1/16: memory function complete, read data.

Function
REQ-012 SHALL implement states IDLE, ACCESS, DONE; registered outputs only.
REQ-013 IDLE: when any req high at a clock edge, SHALL select a winner, latch its rw/addr/wdata into mem_rw/mem_addr/mem_wdata, assert its gnt, and enter ACCESS.
REQ-014 Priority: ls over if, unless if_req is pending and starve_cnt == STARVE_LIM, in which case if wins.
REQ-015 starve_cnt (2 bits) SHALL increment on each ls grant made while if_req is high, saturate at STARVE_LIM, and clear on any if grant or when if_req is low at an arbitration edge.
REQ-016 Fetch writes: if_rw=0 SHALL be performed as a write with mem_wdata=0.
REQ-017 ACCESS: mem_en=1. Each cycle without mem_mfc SHALL increment tmo_cnt (8 bits, cleared on entry).
REQ-018 ACCESS with mem_mfc=1 SHALL capture mem_rdata into rdata if mem_rw=1, otherwise hold rdata, and enter DONE.
REQ-019 ACCESS with tmo_cnt == TIMEOUT and mem_mfc=0 SHALL enter DONE with err flagged and rdata held. If mfc and timeout coincide, mfc wins (no err).
REQ-020 DONE: mem_en=0. SHALL pulse the owner's done (and err if flagged) for exactly 1 cycle, drop gnt, and return to IDLE.
REQ-021 Latency: req seen at edge N gives mem_en=1 from N+1. mfc sampled at edge M gives done high in cycle M+1. Minimum 3 cycles from req to IDLE.
REQ-022 Requesters SHALL hold req and inputs until done; changes during ACCESS SHALL be ignored (latched values used).
REQ-023 A req deasserted during ACCESS SHALL NOT abort the transfer; done still pulses.
REQ-024 At most one gnt SHALL be high at any time; gnt is high only in ACCESS and DONE.
REQ-025 A requester still holding req after DONE SHALL be re-arbitrated in IDLE (no back-to-back grant without an IDLE cycle).
REQ-026 mem_en SHALL never be high in IDLE or DONE.

Reset
REQ-027 rst high SHALL force IDLE immediately and zero all outputs, starve_cnt, tmo_cnt, and the err flag, including mid-ACCESS (transfer dropped, no done).
REQ-028 The first arbitration SHALL occur at the first rising edge after rst deasserts.

Verification
REQ-029 Single ls read: ls_req=1, rw=1, addr=0x0010; mfc after 3 cycles with mem_rdata=0xBEEF -> mem_addr=0x0010, mem_en high for 4 cycles, rdata=0xBEEF, ls_done pulses once.
REQ-030 Simultaneous if_req and ls_req held continuously -> grant order ls, ls, if, ls, ls, if (STARVE_LIM=2); never both gnt.
REQ-031 ls write of 0x1234 to 0x0020 with mfc in the first ACCESS cycle -> mem_rw=0, mem_wdata=0x1234, ls_done 2 cycles after req edge, rdata unchanged.
REQ-032 No mfc, TIMEOUT=15 -> mem_en high for 16 cycles, then ls_done and err pulse together for 1 cycle, IDLE next.
REQ-033 rst asserted during ACCESS -> all outputs 0 asynchronously, no done; after release, a pending if_req is granted on the next edge.
REQ-034 mfc and timeout in the same cycle -> done without err, rdata captured.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter: load/store normally wins, fetch is protected
// from starvation, and each transfer completes on mem_mfc or aborts on timeout.
module mem_bus_arbiter #(
  parameter int TIMEOUT    = 15,
  parameter int STARVE_LIM = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic        if_rw,
  input  logic [15:0] if_addr,
  input  logic        ls_req,
  input  logic        ls_rw,
  input  logic [15:0] ls_addr,
  input  logic [15:0] ls_wdata,
  output logic        if_gnt,
  output logic        if_done,
  output logic        ls_gnt,
  output logic        ls_done,
  output logic [15:0] rdata,
  output logic        err,
  output logic        mem_en,
  output logic        mem_rw,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_mfc,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [7:0] TMO_LIM    = 8'(TIMEOUT);
  localparam logic [1:0] STARVE_MAX = 2'(STARVE_LIM);

  state_t      state;
  logic [1:0]  starve_cnt;
  logic [7:0]  tmo_cnt;
  logic        owner_if;
  logic        if_wins;

  // Fetch takes the bus when it is alone or has already yielded STARVE_LIM times.
  always_comb begin
    if_wins = if_req && (!ls_req || (starve_cnt == STARVE_MAX));
  end

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      tmo_cnt    <= '0;
      owner_if   <= 1'b0;
      if_gnt     <= 1'b0;
      if_done    <= 1'b0;
      ls_gnt     <= 1'b0;
      ls_done    <= 1'b0;
      rdata      <= '0;
      err        <= 1'b0;
      mem_en     <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || ls_req) begin
            state    <= ACCESS;
            mem_en   <= 1'b1;
            tmo_cnt  <= '0;
            owner_if <= if_wins;
            if_gnt   <= if_wins;
            ls_gnt   <= !if_wins;
            if (if_wins) begin
              mem_rw     <= if_rw;
              mem_addr   <= if_addr;
              mem_wdata  <= '0;
              starve_cnt <= '0;
            end else begin
              mem_rw    <= ls_rw;
              mem_addr  <= ls_addr;
              mem_wdata <= ls_wdata;
              if (!if_req)
                starve_cnt <= '0;
              else if (starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 2'd1;
            end
          end else begin
            starve_cnt <= '0;
          end
        end

        ACCESS: begin
          if (mem_mfc) begin
            state   <= DONE;
            mem_en  <= 1'b0;
            if_done <= owner_if;
            ls_done <= !owner_if;
            if (mem_rw)
              rdata <= mem_rdata;
          end else if (tmo_cnt == TMO_LIM) begin
            state   <= DONE;
            mem_en  <= 1'b0;
            if_done <= owner_if;
            ls_done <= !owner_if;
            err     <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end

        DONE: begin
          state   <= IDLE;
          if_done <= 1'b0;
          ls_done <= 1'b0;
          err     <= 1'b0;
          if_gnt  <= 1'b0;
          ls_gnt  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a transaction-level reference model
// checked every cycle, plus directed scenarios with hand-computed results.
module tb_mem_bus_arbiter;

  localparam int TIMEOUT    = 15;
  localparam int STARVE_LIM = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, if_rw = 1'b0;
  logic [15:0] if_addr = '0;
  logic        ls_req = 1'b0, ls_rw = 1'b0;
  logic [15:0] ls_addr = '0, ls_wdata = '0;
  logic        if_gnt, if_done, ls_gnt, ls_done, err;
  logic [15:0] rdata;
  logic        mem_en, mem_rw;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_mfc = 1'b0;
  logic [15:0] mem_rdata = '0;

  mem_bus_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_rw(if_rw), .if_addr(if_addr),
    .ls_req(ls_req), .ls_rw(ls_rw), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .if_gnt(if_gnt), .if_done(if_done), .ls_gnt(ls_gnt), .ls_done(ls_done),
    .rdata(rdata), .err(err),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mfc(mem_mfc), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Memory responder: raise mfc during the mfc_at-th cycle of mem_en (0 = never).
  int mfc_at = 0;
  int acc_cyc = 0;
  always @(negedge clk) begin
    if (mem_en) begin
      acc_cyc++;
      mem_mfc = (mfc_at != 0) && (acc_cyc == mfc_at);
    end else begin
      acc_cyc = 0;
      mem_mfc = 1'b0;
    end
  end

  // Reference model: one outstanding transaction, tracked by its age in bus cycles.
  bit          m_busy, m_fin, m_if, m_rw, m_err;
  logic [15:0] m_addr, m_wdata, m_rdata;
  int          m_starve, m_age;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_fin = 0; m_if = 0; m_rw = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_starve = 0; m_age = 0;
    end else if (m_fin) begin
      m_busy = 0; m_fin = 0; m_err = 0;
    end else if (m_busy) begin
      if (mem_mfc) begin
        if (m_rw) m_rdata = mem_rdata;
        m_fin = 1;
      end else if (m_age == TIMEOUT) begin
        m_fin = 1; m_err = 1;
      end else begin
        m_age++;
      end
    end else if (if_req || ls_req) begin
      bit take_if;
      take_if = if_req && (!ls_req || m_starve >= STARVE_LIM);
      m_busy = 1; m_age = 0; m_if = take_if;
      m_rw    = take_if ? if_rw : ls_rw;
      m_addr  = take_if ? if_addr : ls_addr;
      m_wdata = take_if ? 16'h0 : ls_wdata;
      if (take_if || !if_req) m_starve = 0;
      else if (m_starve < STARVE_LIM) m_starve++;
    end else begin
      m_starve = 0;
    end
  end

  function automatic logic [63:0] dut_vec();
    return {9'd0, if_gnt, if_done, ls_gnt, ls_done, err, mem_en, mem_rw,
            mem_addr, mem_wdata, rdata};
  endfunction

  function automatic logic [63:0] model_vec();
    return {9'd0, m_busy & m_if, m_fin & m_if, m_busy & !m_if, m_fin & !m_if,
            m_fin & m_err, m_busy & !m_fin, m_rw, m_addr, m_wdata, m_rdata};
  endfunction

  always @(negedge clk) begin
    if (!rst) check("cycle", dut_vec(), model_vec());
  end

  // Event counters and grant-order log, observed from the DUT.
  int  en_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  byte gq[$];
  bit  p_if = 0, p_ls = 0;
  always @(negedge clk) begin
    if (mem_en) en_cnt++;
    if (if_done || ls_done) done_cnt++;
    if (err) err_cnt++;
    if (if_gnt && ls_gnt) both_cnt++;
    if (if_gnt && !p_if) gq.push_back("I");
    if (ls_gnt && !p_ls) gq.push_back("L");
    p_if = if_gnt;
    p_ls = ls_gnt;
  end

  task automatic wait_done(output int cyc);
    bit seen = 0;
    cyc = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      cyc++;
      if (if_done || ls_done) begin
        seen = 1;
        break;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
  endtask

  task automatic clear_counts();
    en_cnt = 0; done_cnt = 0; err_cnt = 0;
  endtask

  initial begin
    int cyc;
    logic [47:0] ord, exp_ord;
    logic [15:0] d0;

    // Reset state.
    #12;
    check("reset_outputs", dut_vec(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single ls read, mfc in the 4th access cycle.
    clear_counts();
    mfc_at = 4; mem_rdata = 16'hBEEF;
    ls_req = 1; ls_rw = 1; ls_addr = 16'h0010;
    wait_done(cyc);
    ls_req = 0;
    @(negedge clk);
    check("rd_en_cycles", 64'(en_cnt), 64'd4);
    check("rd_rdata", 64'(rdata), 64'hBEEF);
    check("rd_addr", 64'(mem_addr), 64'h0010);
    check("rd_done_cnt", 64'(done_cnt), 64'd1);

    // ls write with mfc in the first access cycle.
    clear_counts();
    mfc_at = 1; mem_rdata = 16'h7777;
    ls_req = 1; ls_rw = 0; ls_addr = 16'h0020; ls_wdata = 16'h1234;
    wait_done(cyc);
    ls_req = 0;
    check("wr_latency", 64'(cyc), 64'd2);
    check("wr_rw", 64'(mem_rw), 64'd0);
    check("wr_wdata", 64'(mem_wdata), 64'h1234);
    check("wr_rdata_held", 64'(rdata), 64'hBEEF);
    @(negedge clk);

    // Both requesters held: fetch gets every third grant.
    gq.delete();
    mfc_at = 2; mem_rdata = 16'h0A0A;
    if_req = 1; if_rw = 1; if_addr = 16'h0100;
    ls_req = 1; ls_rw = 1; ls_addr = 16'h0200;
    for (int i = 0; i < 200 && gq.size() < 6; i++) @(negedge clk);
    if_req = 0; ls_req = 0;
    wait_done(cyc);
    repeat (3) @(negedge clk);
    check("starve_grant_cnt", 64'(gq.size()), 64'd6);
    ord = '0;
    for (int i = 0; i < 6 && i < gq.size(); i++) ord = {ord[39:0], gq[i]};
    exp_ord = "LLILLI";
    check("starve_order", 64'(ord), 64'(exp_ord));
    check("never_both_gnt", 64'(both_cnt), 64'd0);

    // Fetch write always drives zero write data.
    mfc_at = 2;
    ls_wdata = 16'h5555;
    if_req = 1; if_rw = 0; if_addr = 16'h0030;
    wait_done(cyc);
    if_req = 0;
    check("if_wr_rw", 64'(mem_rw), 64'd0);
    check("if_wr_wdata", 64'(mem_wdata), 64'd0);
    @(negedge clk);

    // Timeout: no mfc at all.
    clear_counts();
    mfc_at = 0;
    ls_req = 1; ls_rw = 1; ls_addr = 16'h0050;
    wait_done(cyc);
    check("tmo_err_with_done", 64'(err), 64'd1);
    ls_req = 0;
    @(negedge clk);
    check("tmo_en_cycles", 64'(en_cnt), 64'd16);
    check("tmo_err_cnt", 64'(err_cnt), 64'd1);
    check("tmo_rdata_held", 64'(rdata), 64'h0A0A);
    check("tmo_idle_next", 64'({if_gnt, ls_gnt, mem_en}), 64'd0);

    // mfc on the same edge as the timeout: completes without error.
    clear_counts();
    mfc_at = 16; mem_rdata = 16'hCAFE;
    ls_req = 1; ls_rw = 1; ls_addr = 16'h0060;
    wait_done(cyc);
    ls_req = 0;
    @(negedge clk);
    check("coin_err_cnt", 64'(err_cnt), 64'd0);
    check("coin_rdata", 64'(rdata), 64'hCAFE);

    // Reset mid-access: transfer dropped, pending fetch granted right after release.
    clear_counts();
    mfc_at = 0;
    ls_req = 1; ls_rw = 1; ls_addr = 16'h0040;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async", dut_vec(), 64'd0);
    ls_req = 0;
    if_req = 1; if_rw = 1; if_addr = 16'h0080;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_if_gnt", 64'({if_gnt, ls_gnt, mem_en}), 64'b101);
    check("rst_if_addr", 64'(mem_addr), 64'h0080);
    d0 = 16'(done_cnt);
    mfc_at = 1;
    wait_done(cyc);
    if_req = 0;
    check("rst_if_done", 64'(if_done), 64'd1);
    @(negedge clk);
    check("rst_no_dropped_done", 64'(done_cnt), 64'(d0) + 64'd1);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
